// File: rtl/oven_pkg.sv
// Shared types and widths for the oven controller.
package oven_pkg;

  localparam int STATE_W = 2;
  localparam int TIME_W  = 8;

  // Encodings match the externally visible state port.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Commands to the remaining-time register.
  typedef enum logic [1:0] {
    CD_HOLD  = 2'd0,
    CD_LOAD  = 2'd1,
    CD_DEC   = 2'd2,
    CD_CLEAR = 2'd3
  } cd_op_e;

endpackage

// File: rtl/oven_countdown.sv
// Remaining-seconds register: load, decrement, clear, never wraps below zero.
module oven_countdown
  import oven_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  cd_op_e            op,
  input  logic [TIME_W-1:0] load_val,
  output logic [TIME_W-1:0] value
);

  logic [TIME_W-1:0] value_d;
  logic [TIME_W-1:0] value_q;

  // Next value from the requested operation; decrement saturates at zero.
  always_comb begin
    // NOTE: assigning the hold value first means every path drives value_d, so no latch is inferred.
    value_d = value_q;
    case (op)
      CD_LOAD:  value_d = load_val;
      CD_DEC:   value_d = (value_q != '0) ? value_q - 1'b1 : '0;
      CD_CLEAR: value_d = '0;
      default:  value_d = value_q;
    endcase
  end

  // Remaining-time register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/oven_ctrl.sv
// Oven controller: cook/pause/done FSM with a completion buzzer timer.
module oven_ctrl
  import oven_pkg::*;
#(
  parameter int BUZZ_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               door_open,
  input  logic               tick,
  input  logic [TIME_W-1:0]  set_time,
  output logic [TIME_W-1:0]  remaining,
  output logic               heater_on,
  output logic               done,
  output logic               buzzer,
  output logic [STATE_W-1:0] state
);

  localparam int BUZZ_W = $clog2(BUZZ_CYCLES + 1);

  state_e            state_d;
  state_e            state_q;
  logic [BUZZ_W-1:0] buzz_d;
  logic [BUZZ_W-1:0] buzz_q;
  cd_op_e            cd_op;
  logic [TIME_W-1:0] remaining_w;

  oven_countdown u_countdown (
    .clk      (clk),
    .rst      (rst),
    .op       (cd_op),
    .load_val (set_time),
    .value    (remaining_w)
  );

  // Next-state, buzz counter and countdown command from the current state.
  always_comb begin
    state_d = state_q;
    buzz_d  = buzz_q;
    cd_op   = CD_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (start && !door_open && (set_time != '0)) begin
          cd_op   = CD_LOAD;
          state_d = ST_COOK;
        end
      end
      ST_COOK: begin
        // Pause wins over a coinciding tick so the interrupted second is not lost.
        if (stop || door_open) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          cd_op = CD_DEC;
          if (remaining_w <= TIME_W'(1)) begin
            state_d = ST_DONE;
            buzz_d  = BUZZ_W'(BUZZ_CYCLES);
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          cd_op   = CD_CLEAR;
          state_d = ST_IDLE;
        end else if (start && !door_open) begin
          state_d = ST_COOK;
        end
      end
      ST_DONE: begin
        if (door_open || stop) begin
          state_d = ST_IDLE;
          buzz_d  = '0;
        end else if (buzz_q != '0) begin
          buzz_d = buzz_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        buzz_d  = '0;
        cd_op   = CD_CLEAR;
      end
    endcase
  end

  // State and buzz counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      buzz_q  <= '0;
    end else begin
      state_q <= state_d;
      buzz_q  <= buzz_d;
    end
  end

  // Moore output decodes of registered state.
  assign remaining = remaining_w;
  assign heater_on = (state_q == ST_COOK);
  assign done      = (state_q == ST_DONE);
  assign buzzer    = (state_q == ST_DONE) && (buzz_q != '0);
  assign state     = state_q;

endmodule

// File: tb/tb_oven_ctrl.sv
// Directed self-checking bench for oven_ctrl.
module tb_oven_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       door_open;
  logic       tick;
  logic [7:0] set_time;
  logic [7:0] remaining;
  logic       heater_on;
  logic       done;
  logic       buzzer;
  logic [1:0] state;

  int vectors     = 0;
  int miscompares = 0;

  oven_ctrl #(.BUZZ_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .door_open (door_open),
    .tick      (tick),
    .set_time  (set_time),
    .remaining (remaining),
    .heater_on (heater_on),
    .done      (done),
    .buzzer    (buzzer),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks every output against expected state/remaining; flags derive from state.
  task automatic check_outs(input string tag, input logic [1:0] st, input logic [7:0] rem,
                            input logic bz);
    check({tag, ".state"},  32'(state),     32'(st));
    check({tag, ".rem"},    32'(remaining), 32'(rem));
    check({tag, ".heater"}, 32'(heater_on), 32'(st == 2'd1));
    check({tag, ".done"},   32'(done),      32'(st == 2'd3));
    check({tag, ".buzzer"}, 32'(buzzer),    32'(bz));
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tick_once();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    int high_cnt;
    rst = 1'b1; start = 1'b0; stop = 1'b0; door_open = 1'b0; tick = 1'b0; set_time = 8'd0;
    #12;
    check_outs("reset", 2'd0, 8'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    check_outs("post_reset", 2'd0, 8'd0, 1'b0);

    // Full cook of 3 s with a tick every 10 clocks, then buzzer duration.
    set_time = 8'd3; start = 1'b1;
    step(); start = 1'b0;
    check_outs("c3_load", 2'd1, 8'd3, 1'b0);
    idle(9); tick_once();
    check_outs("c3_t1", 2'd1, 8'd2, 1'b0);
    idle(9); tick_once();
    check_outs("c3_t2", 2'd1, 8'd1, 1'b0);
    idle(9); tick_once();
    check_outs("c3_t3", 2'd3, 8'd0, 1'b1);
    high_cnt = 0;
    for (int i = 0; i < 20 && buzzer === 1'b1; i++) begin
      high_cnt++;
      step();
    end
    check("buzz_len", 32'(high_cnt), 32'd8);
    check_outs("done_held", 2'd3, 8'd0, 1'b0);
    idle(3);
    check_outs("done_held2", 2'd3, 8'd0, 1'b0);
    stop = 1'b1; step(); stop = 1'b0;
    check_outs("done_stop", 2'd0, 8'd0, 1'b0);

    // Door opens on the same clock as a tick: pause wins, no decrement.
    set_time = 8'd5; start = 1'b1; step(); start = 1'b0;
    check_outs("c5_load", 2'd1, 8'd5, 1'b0);
    tick_once(); step(); tick_once();
    check_outs("c5_t2", 2'd1, 8'd3, 1'b0);
    door_open = 1'b1; tick = 1'b1; step(); tick = 1'b0;
    check_outs("door_tick", 2'd2, 8'd3, 1'b0);
    tick_once();
    check_outs("pause_tick", 2'd2, 8'd3, 1'b0);
    start = 1'b1; step();
    check_outs("pause_door_start", 2'd2, 8'd3, 1'b0);
    door_open = 1'b0; step(); start = 1'b0;
    check_outs("resume", 2'd1, 8'd3, 1'b0);

    // Stop pauses; start+stop together in PAUSE cancels.
    stop = 1'b1; step(); stop = 1'b0;
    check_outs("stop_pause", 2'd2, 8'd3, 1'b0);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    check_outs("cancel", 2'd0, 8'd0, 1'b0);

    // Start ignored with zero time or open door; ticks in IDLE ignored.
    set_time = 8'd0; start = 1'b1; step();
    check_outs("zero_time", 2'd0, 8'd0, 1'b0);
    set_time = 8'd4; door_open = 1'b1; step();
    check_outs("door_start", 2'd0, 8'd0, 1'b0);
    start = 1'b0; door_open = 1'b0; tick_once();
    check_outs("idle_tick", 2'd0, 8'd0, 1'b0);

    // Asynchronous reset mid-cook takes effect before the next edge.
    set_time = 8'd7; start = 1'b1; step(); start = 1'b0;
    check_outs("c7_load", 2'd1, 8'd7, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_outs("async_rst", 2'd0, 8'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_time = 8'd2; start = 1'b1; step(); start = 1'b0;
    check_outs("reload", 2'd1, 8'd2, 1'b0);

    // Finish, start ignored in DONE, door open at buzz cycle 3 returns to IDLE.
    tick_once();
    check_outs("c2_t1", 2'd1, 8'd1, 1'b0);
    tick_once();
    check_outs("c2_done", 2'd3, 8'd0, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    check_outs("done_start", 2'd3, 8'd0, 1'b1);
    step();
    check_outs("buzz3", 2'd3, 8'd0, 1'b1);
    door_open = 1'b1; step(); door_open = 1'b0;
    check_outs("done_door", 2'd0, 8'd0, 1'b0);
    step();
    check_outs("idle_after", 2'd0, 8'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
